mips_multicycle_core: RTL and testbench

Multi-cycle MIPS core that replaces the single-cycle datapath. It shares one ALU and one unified instruction/data memory port across FSM states. The memory port uses a req/ready handshake, so memory may insert wait states. Address width and reset vector are parametrised. Unsupported opcodes and misaligned accesses trap. It sits between the top-level testbench/SoC wrapper and a single memory model.

---
 rtl/mips_multicycle_core.sv | 223 ++++++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core: one shared ALU, one unified memory port with
// req/ready handshake, traps on illegal opcodes and misaligned data accesses.
module mips_multicycle_core #(
    parameter int unsigned         ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              retire,
    output logic [ADDR_W-1:0] pc_dbg,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pcdbg_q, pcdbg_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       alu_q, alu_d;
    logic [31:0]       mdr_q, mdr_d;
    logic [31:0]       regs_q [32];

    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       rf_wdata;

    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd;
    logic [31:0]       sext, pc32, jt;
    logic              is_r, r_ok, is_lw, is_sw, is_beq, is_addi, is_j, legal;

    logic [31:0]       alu_a, alu_b, alu_y;
    alu_op_t           alu_op, funct_op;

    assign op     = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign funct  = ir_q[5:0];
    assign sext   = {{16{ir_q[15]}}, ir_q[15:0]};

    assign is_r    = (op == 6'h00);
    assign is_lw   = (op == 6'h23);
    assign is_sw   = (op == 6'h2B);
    assign is_beq  = (op == 6'h04);
    assign is_addi = (op == 6'h08);
    assign is_j    = (op == 6'h02);

    always_comb begin
        funct_op = ALU_ADD;
        r_ok     = 1'b1;
        case (funct)
            6'h20:   funct_op = ALU_ADD;
            6'h22:   funct_op = ALU_SUB;
            6'h24:   funct_op = ALU_AND;
            6'h25:   funct_op = ALU_OR;
            6'h2A:   funct_op = ALU_SLT;
            default: r_ok = 1'b0;
        endcase
    end

    assign legal = (is_r & r_ok) | is_lw | is_sw | is_beq | is_addi | is_j;

    always_comb begin
        pc32             = '0;
        pc32[ADDR_W-1:0] = pc_q;
    end

    // pc_q already holds PC+4 once FETCH completes
    assign jt = {pc32[31:28], ir_q[25:0], 2'b00};

    // The single ALU computes the branch target in DECODE and the operation in EXEC
    always_comb begin
        alu_a  = a_q;
        alu_b  = is_r ? b_q : sext;
        alu_op = is_r ? funct_op : ALU_ADD;
        if (state_q == S_DECODE) begin
            alu_a  = pc32;
            alu_b  = {sext[29:0], 2'b00};
            alu_op = ALU_ADD;
        end
    end

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pcdbg_d   = pcdbg_q;
        tgt_d     = tgt_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        rf_we     = 1'b0;
        rf_waddr  = rt;
        rf_wdata  = alu_q;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + ADDR_W'(4);
                    pcdbg_d = pc_q;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = regs_q[rs];
                b_d     = regs_q[rt];
                tgt_d   = alu_y[ADDR_W-1:0];
                state_d = legal ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    alu_d   = alu_y;
                    state_d = (alu_y[1:0] != 2'b00) ? S_TRAP : S_MEM;
                end else if (is_beq) begin
                    if (a_q == b_q) pc_d = tgt_q;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_j) begin
                    pc_d    = jt[ADDR_W-1:0];
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    alu_d   = alu_y;
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = is_sw;
                mem_addr = alu_q[ADDR_W-1:0];
                if (mem_ready) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = is_r ? rd : rt;
                rf_wdata = is_lw ? mdr_q : alu_q;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    assign mem_wdata = b_q;
    assign pc_dbg    = pcdbg_q;
    assign halted    = (state_q == S_TRAP);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            pcdbg_q <= RESET_PC;
            tgt_q   <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pcdbg_q <= pcdbg_d;
            tgt_q   <= tgt_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: small programs run from a memory model
// with configurable wait states; register values are observed through stores.
module tb_mips_multicycle_core;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

    always #5 clock = ~clock;

    mips_multicycle_core #(.ADDR_W(32), .RESET_PC(32'h100)) dut (
        .clock     (clock),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .retire    (retire),
        .pc_dbg    (pc_dbg),
        .halted    (halted)
    );

    localparam logic [31:0] ILL = 32'hFC00_0000;

    // Memory model: program image in rom, stores in dram tagged by scenario epoch
    logic [31:0] rom   [0:1023];
    logic [31:0] dram  [0:1023];
    int unsigned wr_ep [0:1023];
    int unsigned epoch = 0;
    int unsigned wait_n = 0;
    int unsigned cnt = 0;
    logic [9:0]  idx;

    assign idx       = mem_addr[11:2];
    assign mem_rdata = (wr_ep[idx] == epoch) ? dram[idx] : rom[idx];
    assign mem_ready = mem_req && (cnt >= wait_n);

    logic [31:0] tx_addr [$];
    logic        tx_we   [$];
    logic [31:0] tx_wd   [$];

    always @(posedge clock) begin
        if (mem_req && !mem_ready) cnt <= cnt + 1;
        else                       cnt <= 0;
        if (mem_req && mem_ready) begin
            tx_addr.push_back(mem_addr);
            tx_we.push_back(mem_we);
            tx_wd.push_back(mem_wdata);
            if (mem_we) begin
                dram[idx]  <= mem_wdata;
                wr_ep[idx] <= epoch;
            end
        end
    end

    // Cycle counter, retire log and hold-stable monitor
    int          cyc = 0;
    int          ret_cyc [$];
    int          stab_err = 0;
    logic        pend = 1'b0, p_we = 1'b0;
    logic [31:0] p_addr = '0, p_wd = '0;

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (retire) ret_cyc.push_back(cyc);
        if (reset && pend && (!mem_req || mem_addr !== p_addr || mem_we !== p_we ||
                              (p_we && mem_wdata !== p_wd)))
            stab_err = stab_err + 1;
        pend   = reset && mem_req && !mem_ready;
        p_addr = mem_addr;
        p_we   = mem_we;
        p_wd   = mem_wdata;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] wa [$];
    logic [31:0] wd [$];
    logic [31:0] fa [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(fn)};
    endfunction

    function automatic logic [31:0] enc_j(input int tgt);
        return {6'h02, 26'(tgt)};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) rom[i] = ILL;
        epoch = epoch + 1;
    endtask

    task automatic put(input int addr, input logic [31:0] w);
        rom[addr >> 2] = w;
    endtask

    function automatic int ret_in(input int lo, input int hi);
        int n = 0;
        foreach (ret_cyc[i]) if (ret_cyc[i] >= lo && ret_cyc[i] <= hi) n++;
        return n;
    endfunction

    function automatic logic [31:0] at(input logic [31:0] q[$], input int k);
        return (k < q.size()) ? q[k] : 32'hDEAD_BEEF;
    endfunction

    task automatic collect(input int base);
        wa.delete(); wd.delete(); fa.delete();
        for (int i = base; i < int'(tx_addr.size()); i++) begin
            if (tx_we[i]) begin
                wa.push_back(tx_addr[i]);
                wd.push_back(tx_wd[i]);
            end else begin
                fa.push_back(tx_addr[i]);
            end
        end
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 400 && !halted; i++) step();
        chk(tag, 32'(halted), 32'd1);
    endtask

    // Holds reset for three cycles, releases it, and leaves time at FETCH of RESET_PC
    task automatic restart(output int tb, output int rb);
        reset = 1'b0;
        step(); step(); step();
        tb = tx_addr.size();
        rb = ret_cyc.size();
        reset = 1'b1;
        step();
    endtask

    initial begin
        int tb0, rb0, c1, r0, t0;
        bit hit;
        reset = 1'b0;

        // Reset values and ALU program at RESET_PC
        clear_mem();
        put('h100, enc_i('h08, 0, 1, 5));
        put('h104, enc_i('h08, 0, 2, -3));
        put('h108, enc_r(1, 2, 3, 'h20));
        put('h10C, enc_r(2, 1, 4, 'h2A));
        put('h110, enc_r(2, 1, 5, 'h22));
        put('h114, enc_i('h2B, 0, 3, 'h200));
        put('h118, enc_i('h2B, 0, 4, 'h204));
        put('h11C, enc_i('h2B, 0, 5, 'h208));
        step(); step();
        chk("rst_req",    32'(mem_req),   32'd0);
        chk("rst_we",     32'(mem_we),    32'd0);
        chk("rst_addr",   mem_addr,       32'h100);
        chk("rst_wdata",  mem_wdata,      32'h0);
        chk("rst_retire", 32'(retire),    32'd0);
        chk("rst_pcdbg",  pc_dbg,         32'h100);
        chk("rst_halted", 32'(halted),    32'd0);
        reset = 1'b1;
        chk("idle_req", 32'(mem_req), 32'd0);
        tb0 = tx_addr.size();
        rb0 = ret_cyc.size();
        step();
        chk("first_req",  32'(mem_req), 32'd1);
        chk("first_addr", mem_addr,      32'h100);
        chk("first_we",   32'(mem_we),   32'd0);
        c1 = cyc;
        repeat (19) step();
        chk("alu_ret_20cyc", 32'(ret_in(c1, c1 + 19)), 32'd5);
        wait_halt("alu_halt");
        collect(tb0);
        chk("alu_nwr", 32'(wa.size()), 32'd3);
        chk("alu_r3",  at(wd, 0), 32'h2);
        chk("alu_a3",  at(wa, 0), 32'h200);
        chk("alu_r4",  at(wd, 1), 32'h1);
        chk("alu_r5",  at(wd, 2), 32'hFFFF_FFF8);
        chk("alu_a5",  at(wa, 2), 32'h208);
        r0 = ret_cyc.size();
        t0 = tx_addr.size();
        repeat (10) step();
        chk("trap_req",    32'(mem_req), 32'd0);
        chk("trap_notx",   32'(tx_addr.size()), 32'(t0));
        chk("trap_noret",  32'(ret_cyc.size() - rb0), 32'd8);
        chk("trap_sticky", 32'(halted), 32'd1);
        chk("trap_noret2", 32'(ret_cyc.size()), 32'(r0));

        // Store then load with three wait states per transaction
        clear_mem();
        put('h100, enc_i('h08, 0, 1, 5));
        put('h104, enc_i('h2B, 0, 1, 8));
        put('h108, enc_i('h23, 0, 6, 8));
        put('h10C, enc_i('h2B, 0, 6, 'h20C));
        wait_n = 3;
        restart(tb0, rb0);
        wait_halt("wait_halt");
        collect(tb0);
        chk("wait_sw_addr", at(wa, 0), 32'h8);
        chk("wait_sw_data", at(wd, 0), 32'h5);
        chk("wait_r6",      at(wd, 1), 32'h5);
        chk("wait_nret",    32'(ret_cyc.size() - rb0), 32'd4);
        if (ret_cyc.size() - rb0 >= 3) begin
            chk("wait_sw_cyc", 32'(ret_cyc[rb0 + 1] - ret_cyc[rb0]), 32'd10);
            chk("wait_lw_cyc", 32'(ret_cyc[rb0 + 2] - ret_cyc[rb0 + 1]), 32'd11);
        end
        chk("wait_stable", 32'(stab_err), 32'd0);
        wait_n = 0;

        // Taken beq, jumps, and a not-taken beq
        clear_mem();
        put('h100, enc_i('h08, 0, 1, 5));
        put('h104, enc_j(0));
        put('h000, enc_i('h04, 0, 0, 2));
        put('h00C, enc_j('h10));
        put('h040, enc_i('h04, 1, 0, 5));
        restart(tb0, rb0);
        wait_halt("br_halt");
        collect(tb0);
        chk("br_nfetch", 32'(fa.size()), 32'd6);
        chk("br_f2", at(fa, 2), 32'h000);
        chk("br_f3", at(fa, 3), 32'h00C);
        chk("br_f4", at(fa, 4), 32'h040);
        chk("br_f5", at(fa, 5), 32'h044);
        chk("br_pcdbg", pc_dbg, 32'h044);
        chk("br_nret", 32'(ret_cyc.size() - rb0), 32'd5);

        // Writes to $0 are discarded
        clear_mem();
        put('h100, enc_i('h08, 0, 7, 9));
        put('h104, enc_i('h08, 0, 0, 7));
        put('h108, enc_r(0, 0, 7, 'h20));
        put('h10C, enc_i('h2B, 0, 7, 'h210));
        restart(tb0, rb0);
        wait_halt("z_halt");
        collect(tb0);
        chk("z_addr", at(wa, 0), 32'h210);
        chk("z_r7",   at(wd, 0), 32'h0);

        // Misaligned load traps before any data request
        clear_mem();
        put('h100, enc_i('h23, 0, 6, 6));
        restart(tb0, rb0);
        wait_halt("mis_halt");
        repeat (3) step();
        collect(tb0);
        chk("mis_ntx",  32'(tx_addr.size() - tb0), 32'd1);
        chk("mis_f0",   at(fa, 0), 32'h100);
        chk("mis_nret", 32'(ret_cyc.size() - rb0), 32'd0);

        // Asynchronous reset while a load waits on the memory
        clear_mem();
        put('h100, enc_i('h08, 0, 1, 5));
        put('h104, enc_i('h23, 0, 2, 'h300));
        put('h300, 32'h1234_5678);
        wait_n = 20;
        restart(tb0, rb0);
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            if (mem_req && !mem_we && mem_addr == 32'h300) hit = 1'b1;
            else step();
        end
        chk("ar_reach_mem", 32'(hit), 32'd1);
        step(); step();
        reset = 1'b0;
        #1;
        chk("ar_req_drop", 32'(mem_req), 32'd0);
        chk("ar_nret",     32'(ret_cyc.size() - rb0), 32'd1);
        clear_mem();
        put('h100, enc_i('h2B, 0, 1, 'h220));
        put('h104, enc_i('h2B, 0, 2, 'h224));
        wait_n = 0;
        restart(tb0, rb0);
        chk("ar_refetch", mem_addr, 32'h100);
        wait_halt("ar_halt");
        collect(tb0);
        chk("ar_nwr", 32'(wa.size()), 32'd2);
        chk("ar_r1",  at(wd, 0), 32'h0);
        chk("ar_r2",  at(wd, 1), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
